// File: rtl/score_keeper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | score_keeper_pkg : shared state encoding and score limits for score_keeper |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_LOCKOUT = 2'd1,
    ST_WON     = 2'd2
  } state_t;

  localparam int BCD_MAX_DIGIT = 9;
  localparam int SCORE_MAX     = 99;
  localparam int SCORE_W       = 7;

endpackage
`default_nettype wire

// File: rtl/score_bcd_digit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | score_bcd_digit : single BCD digit 0..9 with increment, clear and carry-out |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module score_bcd_digit
  import score_keeper_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Clear,
  input  logic       i_Inc,
  output logic [3:0] o_Digit,
  output logic       o_Carry
);

  logic [3:0] r_Digit;
  logic       w_At_Max;

  assign w_At_Max = (r_Digit == 4'(BCD_MAX_DIGIT));
  assign o_Carry  = i_Inc & w_At_Max;
  assign o_Digit  = r_Digit;

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) begin
      r_Digit <= 4'd0;
    end else if (i_Inc) begin
      r_Digit <= w_At_Max ? 4'd0 : r_Digit + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | score_keeper : point counter with lockout, BCD digits and win detection.   |
// | Optional macro SCORE_WRAP_EN: 99 + point wraps to 00 instead of saturating.|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE      = 11,
  parameter int LOCKOUT_CYCLES = 25_000_000
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Point,
  input  logic               i_Clear,
  output logic [SCORE_W-1:0] o_Score,
  output logic [3:0]         o_Score_Tens,
  output logic [3:0]         o_Score_Ones,
  output logic               o_Point_Strobe,
  output logic               o_Win
);

  localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);

`ifdef SCORE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  generate
    if (WIN_SCORE < 0 || WIN_SCORE > SCORE_MAX) begin : g_bad_win_score
      $error("score_keeper: WIN_SCORE must be within 0..99");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
      $error("score_keeper: LOCKOUT_CYCLES must be at least 1");
    end
  endgenerate

  state_t             r_State;
  logic [CNT_W-1:0]   r_Lock_Cnt;
  logic               r_Point_Prev;
  logic [SCORE_W-1:0] r_Score;
  logic               r_Strobe;
  logic               r_Win;

  logic               w_Edge;
  logic               w_At_Max;
  logic               w_Count;
  logic               w_Win_Hit;
  logic               w_Ones_Carry;
  logic               w_Tens_Carry;
  logic [SCORE_W-1:0] w_Score_Next;
  logic [3:0]         w_Ones;
  logic [3:0]         w_Tens;

  assign w_Edge   = i_Point & ~r_Point_Prev;
  assign w_At_Max = (r_Score == SCORE_W'(SCORE_MAX));

  // Clear beats a coincident edge; at 99 the point is dropped unless wrapping.
  assign w_Count = (r_State == ST_PLAY) & w_Edge & ~i_Clear & (WRAP_EN | ~w_At_Max);

  // Tens carry only fires on the 99 -> 00 rollover, keeping binary and BCD aligned.
  assign w_Score_Next = w_Tens_Carry ? '0 : r_Score + SCORE_W'(1);
  assign w_Win_Hit    = (WIN_SCORE != 0) && (w_Score_Next == SCORE_W'(WIN_SCORE));

  score_bcd_digit u_ones (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Clear (i_Clear),
    .i_Inc   (w_Count),
    .o_Digit (w_Ones),
    .o_Carry (w_Ones_Carry)
  );

  score_bcd_digit u_tens (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Clear (i_Clear),
    .i_Inc   (w_Ones_Carry),
    .o_Digit (w_Tens),
    .o_Carry (w_Tens_Carry)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State      <= ST_PLAY;
      r_Lock_Cnt   <= '0;
      r_Point_Prev <= 1'b0;
      r_Score      <= '0;
      r_Strobe     <= 1'b0;
      r_Win        <= 1'b0;
    end else begin
      r_Point_Prev <= i_Point;
      r_Strobe     <= 1'b0;
      if (i_Clear) begin
        r_State    <= ST_PLAY;
        r_Lock_Cnt <= '0;
        r_Score    <= '0;
        r_Win      <= 1'b0;
      end else begin
        case (r_State)
          ST_PLAY: begin
            if (w_Count) begin
              r_Score    <= w_Score_Next;
              r_Strobe   <= 1'b1;
              r_Lock_Cnt <= '0;
              if (w_Win_Hit) begin
                r_State <= ST_WON;
                r_Win   <= 1'b1;
              end else begin
                r_State <= ST_LOCKOUT;
              end
            end
          end
          ST_LOCKOUT: begin
            if (r_Lock_Cnt == CNT_W'(LOCKOUT_CYCLES - 1)) begin
              r_Lock_Cnt <= '0;
              r_State    <= ST_PLAY;
            end else begin
              r_Lock_Cnt <= r_Lock_Cnt + CNT_W'(1);
            end
          end
          ST_WON: begin
            r_Win <= 1'b1;
          end
          default: begin
            r_State <= ST_PLAY;
          end
        endcase
      end
    end
  end

  assign o_Score        = r_Score;
  assign o_Score_Tens   = w_Tens;
  assign o_Score_Ones   = w_Ones;
  assign o_Point_Strobe = r_Strobe;
  assign o_Win          = r_Win;

endmodule
`default_nettype wire
